// File: rtl/il1_cache_nway_if.sv
// il1_cache_nway_if: fetch, L2 refill, back-invalidate and flush signals of the L1 I-cache.
//   pc/fetch_req -> inst_fetch/inst_valid/icc_halt      core fetch side
//   fill_req/fill_addr -> fill_valid/fill_data          L2 line refill, one word per beat
//   inval_req/inval_addr -> inval_ack                   L2 back-invalidate handshake
//   flush                                               whole-cache invalidate pulse
//   master: core/L2 side, slave: the cache
interface il1_cache_nway_if #(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32,
    parameter int LADDR_W     = 28
);
    logic [PC_LENGTH-1:0]   pc;
    logic                   fetch_req;
    logic [INST_LENGTH-1:0] inst_fetch;
    logic                   inst_valid;
    logic                   icc_halt;
    logic                   fill_req;
    logic [LADDR_W-1:0]     fill_addr;
    logic                   fill_valid;
    logic [INST_LENGTH-1:0] fill_data;
    logic                   inval_req;
    logic [LADDR_W-1:0]     inval_addr;
    logic                   inval_ack;
    logic                   flush;

    modport master (
        output pc, fetch_req, fill_valid, fill_data, inval_req, inval_addr, flush,
        input  inst_fetch, inst_valid, icc_halt, fill_req, fill_addr, inval_ack
    );

    modport slave (
        input  pc, fetch_req, fill_valid, fill_data, inval_req, inval_addr, flush,
        output inst_fetch, inst_valid, icc_halt, fill_req, fill_addr, inval_ack
    );
endinterface

// File: rtl/il1_cache_nway.sv
// il1_cache_nway: N-way set-associative L1 I-cache, tree pseudo-LRU, word-beat L2 refill.
//   clk_l1  rising-edge clock
//   rst_n   synchronous active-low reset
//   bus     il1_cache_nway_if.slave: fetch (pc, fetch_req, inst_fetch, inst_valid, icc_halt),
//           refill (fill_req, fill_addr, fill_valid, fill_data),
//           back-invalidate (inval_req, inval_addr, inval_ack), flush
module il1_cache_nway #(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32,
    parameter int WAYS        = 4,
    parameter int SETS        = 64,
    parameter int LINE_WORDS  = 4
) (
    input logic clk_l1,
    input logic rst_n,
    il1_cache_nway_if.slave bus
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = PC_LENGTH - 2 - OFF_W - IDX_W;
    localparam int LADDR_W = PC_LENGTH - 2 - OFF_W;
    localparam int WAY_W   = $clog2(WAYS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_nx;

    logic [INST_LENGTH-1:0] data [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]       tags [WAYS][SETS];
    logic [SETS-1:0]        valid [WAYS];
    logic [WAYS-2:0]        plru [SETS];

    logic [OFF_W-1:0] cnt;
    logic [WAY_W-1:0] victim, victim_nx, hit_way, plru_way;
    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-2:0]  pset;
    logic             flush_pend, ack_q, hit, idle, inval_svc, miss_start, fill_beat, last_beat;

    logic [IDX_W-1:0] idx, iidx;
    logic [OFF_W-1:0] off;
    logic [TAG_W-1:0] tag, itag;
    logic             unused_pc;

    assign idx       = bus.pc[2+OFF_W +: IDX_W];
    assign off       = bus.pc[2 +: OFF_W];
    assign tag       = bus.pc[PC_LENGTH-1 -: TAG_W];
    assign iidx      = bus.inval_addr[IDX_W-1:0];
    assign itag      = bus.inval_addr[LADDR_W-1 -: TAG_W];
    assign unused_pc = ^bus.pc[1:0];

    assign idle       = state == IDLE;
    assign hit        = |hit_vec;
    // An invalidate steals the IDLE cycle; a miss seen in that cycle starts on the next one.
    assign inval_svc  = idle && bus.inval_req && !ack_q;
    assign miss_start = idle && bus.fetch_req && !hit && !inval_svc;
    assign fill_beat  = !idle && bus.fill_valid;
    assign last_beat  = fill_beat && cnt == OFF_W'(LINE_WORDS - 1);

    // Tree node for level l on the path to way a is (2^l - 1) + (top l bits of a);
    // each node on that path is set to point at the sibling subtree.
    function automatic logic [WAYS-2:0] plru_upd(input logic [WAYS-2:0] p, input logic [WAY_W-1:0] a);
        logic [WAYS-2:0]  q;
        logic [WAY_W-1:0] s;
        q = p;
        for (int l = 0; l < WAY_W; l++) begin
            s = a >> (WAY_W - 1 - l);
            q[WAY_W'((1 << l) - 1) + (a >> (WAY_W - l))] = ~s[0];
        end
        return q;
    endfunction

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[w][idx] && tags[w][idx] == tag;
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    // Walk the PLRU tree to a leaf, then prefer the lowest invalid way.
    always_comb begin
        pset     = plru[idx];
        plru_way = '0;
        for (int l = 0; l < WAY_W; l++)
            plru_way = WAY_W'({plru_way, pset[WAY_W'((1 << l) - 1) + plru_way]});
        victim_nx = plru_way;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w][idx]) victim_nx = WAY_W'(w);
    end

    always_ff @(posedge clk_l1) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (idle && miss_start)      state_nx = FILL;
        else if (!idle && last_beat) state_nx = IDLE;
    end

    always_comb begin
        bus.inst_valid = idle && bus.fetch_req && hit;
        bus.inst_fetch = data[hit_way][idx][off];
        bus.icc_halt   = idle ? bus.fetch_req && !hit : 1'b1;
        bus.fill_req   = !idle;
        bus.fill_addr  = bus.pc[PC_LENGTH-1:2+OFF_W];
        bus.inval_ack  = ack_q;
    end

    always_ff @(posedge clk_l1) begin
        if (!rst_n) begin
            cnt        <= '0;
            flush_pend <= 1'b0;
            ack_q      <= 1'b0;
            victim     <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else begin
            ack_q <= inval_svc;
            if (miss_start) victim <= victim_nx;
            if (bus.inst_valid) plru[idx] <= plru_upd(plru[idx], hit_way);
            if (inval_svc)
                for (int w = 0; w < WAYS; w++)
                    if (tags[w][iidx] == itag) valid[w][iidx] <= 1'b0;
            if (fill_beat) cnt <= cnt + 1'b1;
            if (last_beat) begin
                cnt        <= '0;
                flush_pend <= 1'b0;
                if (!flush_pend && !bus.flush) begin
                    valid[victim][idx] <= 1'b1;
                    plru[idx]          <= plru_upd(plru[idx], victim);
                end
            end
            if (bus.flush) begin
                for (int w = 0; w < WAYS; w++) valid[w] <= '0;
                if (idle) for (int s = 0; s < SETS; s++) plru[s] <= '0;
                else if (!last_beat) flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_l1) begin
        if (fill_beat) begin
            data[victim][idx][cnt] <= bus.fill_data;
            if (last_beat) tags[victim][idx] <= tag;
        end
    end

    always_ff @(posedge clk_l1)
        if (rst_n && idle) assert ($onehot0(hit_vec));
endmodule

// File: doc/il1_cache_nway.md
Name: il1_cache_nway

Overview:
Parametrised N-way set-associative L1 instruction cache with a word-beat refill interface to L2. Tree pseudo-LRU replacement. Supports L2 back-invalidation (inclusion) with ack, and a whole-cache flush. Sits between the fetch stage (pc in, instruction out, halt out) and the L2 instruction port.

Parameters:
PC_LENGTH, 32, fetch address width
INST_LENGTH, 32, instruction/refill beat width
WAYS, 4, associativity; power of 2, >=2
SETS, 64, number of sets; power of 2
LINE_WORDS, 4, instructions per line; power of 2, >=2
Derived: OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(SETS), TAG_W=PC_LENGTH-2-OFF_W-IDX_W, LADDR_W=PC_LENGTH-2-OFF_W

Ports:
clk_l1  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
pc  in  PC_LENGTH  fetch address; word aligned; held stable by core while icc_halt=1
fetch_req  in  1  fetch request valid
inst_fetch  out  INST_LENGTH  instruction; valid when inst_valid=1
inst_valid  out  1  fetch hit this cycle
icc_halt  out  1  stall fetch
fill_req  out  1  refill request, level
fill_addr  out  LADDR_W  line address of miss = pc[PC_LENGTH-1:2+OFF_W]
fill_valid  in  1  refill beat valid
fill_data  in  INST_LENGTH  refill beat, words in order 0..LINE_WORDS-1
inval_req  in  1  L2 back-invalidate request, level, held until ack
inval_addr  in  LADDR_W  line address to invalidate
inval_ack  out  1  one-cycle ack pulse
flush  in  1  invalidate entire cache, single-cycle pulse

Behaviour:
- Reset (rst_n=0 at edge): all valid bits 0, all PLRU bits 0, state IDLE, beat counter 0, flush_pend 0. Outputs: fill_req=0, inval_ack=0, inst_valid=0, icc_halt=0. Data/tag arrays not reset. Reset mid-fill abandons the fill; remaining beats are ignored (state IDLE).
- Arrays are flop/async-read. Lookup is combinational in IDLE: hit = any way with valid && tag match at index pc[2+OFF_W+IDX_W-1:2+OFF_W]. More than one hitting way is illegal (assertion).
- IDLE, fetch_req=1, hit: inst_valid=1; inst_fetch = hit way's word pc[2+OFF_W-1:2]; icc_halt=0; PLRU of the set updated to point away from the hit way.
- IDLE, fetch_req=1, miss, no inval_req: icc_halt=1; victim latched (lowest-index invalid way, else PLRU victim); next state FILL.
- FILL: fill_req=1, fill_addr from pc, icc_halt=1, inst_valid=0.
  - Each fill_valid beat writes the victim data word at the counter position and increments the counter.
  - On the beat where the counter = LINE_WORDS-1: tag written; valid set unless flush_pend; PLRU updated toward the victim unless flush_pend; counter cleared; flush_pend cleared; state IDLE.
  - fill_req drops the cycle after the last beat. The re-lookup in IDLE then hits (1 fill-to-use bubble).
- fill_valid outside FILL: ignored.
- PLRU: WAYS-1 bits per set, binary tree. Bit=0 means victim is in the lower half. Update sets the bits on the accessed way's path to point away from it.
- Invalidate: serviced only in IDLE. If inval_req=1 in IDLE, it takes priority over a miss that cycle (the miss starts next cycle, icc_halt=1 that cycle).
  - Any valid way matching inval_addr is cleared; PLRU untouched.
  - inval_ack=1 for exactly one cycle (the next cycle); the same request is not re-serviced while ack is high.
  - A no-match still acks.
  - During FILL, inval_req waits; ack follows return to IDLE.
- Flush in IDLE: all valid bits and PLRU cleared next edge. A hit in the same cycle is still delivered.
- Flush in FILL: all valid bits cleared, flush_pend=1, and the in-flight line is not validated. The core re-misses and refetches.
- Flush and inval in the same cycle: flush applied; inval still acked.

Test Plan:
- Cold miss: WAYS=4, LINE_WORDS=4, pc=0x0000_0104, fetch_req=1 -> fill_req=1, fill_addr=0x0000_0010. Drive 4 beats 0xA0..0xA3 -> fill_req low after last beat; next cycle inst_valid=1, inst_fetch=0xA1, icc_halt=0.
- PLRU: fill five distinct tags into set 0 (ways 0,1,2,3 via invalid-first), touch way 0 again, fill a fifth tag -> victim is way 2; re-fetching the original way-2 tag misses, way 0 tag hits.
- Back-invalidate: after a valid line at 0x10, inval_req with inval_addr=0x10 -> one-cycle inval_ack; a subsequent fetch of 0x104 misses. With inval_addr=0x11 -> ack, line still hits.
- Simultaneous: IDLE miss on pc=0x200 with inval_req=1 -> inval_ack next cycle, fill_req rises one cycle later, icc_halt=1 throughout.
- Flush mid-fill: flush pulse after beat 1 of 4 -> fill completes (4 beats consumed), no hit; fill_req reasserts for same address, second fill completes, then hit.
- Reset mid-fill: rst_n=0 for one edge after beat 2 -> fill_req=0, icc_halt=0 with fetch_req=0. Stray fill_valid ignored. Fetch of the same pc misses with a full new 4-beat fill.
